// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between IFU and LSU
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_ifu_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;
  logic [CNT_W-1:0]  r_wdog;
  logic              r_err;

  logic              w_idle;
  logic              w_busy;
  logic              w_pick_lsu;
  logic              w_ifu_hs;
  logic              w_lsu_hs;
  logic              w_timeout;
  logic              w_capture;
  logic [DATA_W-1:0] w_capture_data;

  // Requests are only offered in IDLE; on a tie the requester not served last time wins.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_busy     = (r_state == S_REQ) || (r_state == S_RESP);
  assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || (r_last_grant == OWN_IFU));
  assign w_lsu_hs   = w_idle && w_pick_lsu;
  assign w_ifu_hs   = w_idle && ifu_req_valid && !w_pick_lsu;

  // Watchdog fires on the TIMEOUT-th busy cycle so DONE lands TIMEOUT cycles after entering REQ.
  assign w_timeout  = (TIMEOUT > 0) && w_busy && (r_wdog == WD_LIMIT);

  // Response data is captured either from memory or as zero for stores and timeouts.
  assign w_capture      = w_timeout || ((r_state == S_RESP) && mem_resp_valid);
  assign w_capture_data = (w_timeout || r_wen) ? '0 : mem_rdata;

  assign ifu_req_ready  = w_ifu_hs;
  assign lsu_req_ready  = w_lsu_hs;
  assign mem_req_valid  = (r_state == S_REQ);
  assign mem_addr       = r_addr;
  assign mem_wen        = r_wen;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;
  assign ifu_resp_valid = (r_state == S_DONE) && (r_owner == OWN_IFU);
  assign lsu_resp_valid = (r_state == S_DONE) && (r_owner == OWN_LSU);
  assign ifu_rdata      = r_ifu_rdata;
  assign lsu_rdata      = r_lsu_rdata;
  assign err            = r_err;

  // Transaction FSM: accept, present to memory, wait for response, deliver for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IFU;
      r_last_grant <= OWN_IFU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_wdog       <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_lsu_hs) begin
            r_addr       <= lsu_addr;
            r_wen        <= lsu_wen;
            r_wdata      <= lsu_wdata;
            r_wmask      <= lsu_wen ? lsu_wmask : '0;
            r_owner      <= OWN_LSU;
            r_last_grant <= OWN_LSU;
            r_wdog       <= '0;
            r_state      <= S_REQ;
          end else if (w_ifu_hs) begin
            r_addr       <= ifu_addr;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_IFU;
            r_wdog       <= '0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (mem_req_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (mem_resp_valid) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-requester read data registers hold their value until that owner's next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else if (w_capture) begin
      if (r_owner == OWN_LSU) begin
        r_lsu_rdata <= w_capture_data;
      end else begin
        r_ifu_rdata <= w_capture_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        ifu_v;
    logic        lsu_v;
    logic [31:0] ifu_a;
    logic [31:0] lsu_a;
    logic        lsu_we;
    logic [31:0] lsu_wd;
    logic [3:0]  lsu_wm;
    logic [31:0] mem_rd;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Reference model state for the randomized phase.
  logic        m_busy;
  logic        m_owner_lsu;
  logic        m_last_lsu;
  logic [31:0] m_addr;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_exp_data;
  int          m_age;
  int          m_done;
  logic [31:0] ref_mem [4];
  logic [31:0] sim_mem [4];
  logic        r_pend;
  logic [31:0] r_data;
  int          q_wait;
  int          s_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic clear_inputs();
    ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    tick();
    ifu_req_valid = v.ifu_v; ifu_addr = v.ifu_a;
    lsu_req_valid = v.lsu_v; lsu_addr = v.lsu_a; lsu_wen = v.lsu_we;
    lsu_wdata = v.lsu_wd; lsu_wmask = v.lsu_wm;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = v.mem_rd;
    @(negedge clk);
    chk({t, "_ifu_ready"}, ifu_req_ready, !v.exp_lsu);
    chk({t, "_lsu_ready"}, lsu_req_ready, v.exp_lsu);
    tick();
    ifu_req_valid = 0; lsu_req_valid = 0;
    ifu_addr = 32'hFFFF_FFF0; lsu_addr = 32'hFFFF_FFF0; lsu_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk({t, "_mem_valid"}, mem_req_valid, 1);
    chk({t, "_mem_addr"}, mem_addr, v.exp_addr);
    chk({t, "_mem_wen"}, mem_wen, v.exp_wen);
    chk({t, "_mem_wdata"}, mem_wdata, v.exp_wdata);
    chk({t, "_mem_wmask"}, mem_wmask, v.exp_wmask);
    tick();
    @(negedge clk);
    chk({t, "_resp_phase"}, {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 0);
    tick();
    @(negedge clk);
    chk({t, "_resp_valids"}, {ifu_resp_valid, lsu_resp_valid}, v.exp_lsu ? 2'b01 : 2'b10);
    chk({t, "_rdata"}, v.exp_lsu ? lsu_rdata : ifu_rdata, v.exp_rdata);
  endtask

  task automatic rnd_cycle(input bit allow_req);
    logic ex_i, ex_l;
    logic [1:0] idx;
    tick();
    ifu_req_valid = allow_req && ($urandom_range(0, 2) != 0);
    lsu_req_valid = allow_req && ($urandom_range(0, 2) != 0);
    ifu_addr  = 32'h100 + 4 * $urandom_range(0, 3);
    lsu_addr  = 32'h100 + 4 * $urandom_range(0, 3);
    lsu_wen   = $urandom_range(0, 1);
    lsu_wdata = $urandom;
    lsu_wmask = 4'($urandom_range(0, 15));
    if (mem_req_valid) begin
      mem_req_ready = (q_wait >= 2) || ($urandom_range(0, 1) == 1);
      q_wait++;
    end else begin
      mem_req_ready = $urandom_range(0, 1);
      q_wait = 0;
    end
    if (r_pend) begin
      mem_resp_valid = (s_wait >= 2) || ($urandom_range(0, 1) == 1);
      mem_rdata = r_data;
      s_wait++;
    end else begin
      mem_resp_valid = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
    @(negedge clk);
    ex_i = 0; ex_l = 0;
    if (!m_busy) begin
      if (ifu_req_valid && lsu_req_valid) begin
        ex_l = !m_last_lsu; ex_i = m_last_lsu;
      end else begin
        ex_i = ifu_req_valid; ex_l = lsu_req_valid;
      end
    end
    chk("rnd_ifu_ready", ifu_req_ready, ex_i);
    chk("rnd_lsu_ready", lsu_req_ready, ex_l);
    if (ex_i || ex_l) begin
      m_busy = 1; m_owner_lsu = ex_l; m_last_lsu = ex_l; m_age = 0;
      m_addr  = ex_l ? lsu_addr : ifu_addr;
      m_wen   = ex_l && lsu_wen;
      m_wdata = lsu_wdata;
      m_wmask = m_wen ? lsu_wmask : 4'h0;
      idx = m_addr[3:2];
      if (m_wen) begin
        ref_mem[idx] = apply_mask(ref_mem[idx], lsu_wdata, lsu_wmask);
        m_exp_data = 0;
      end else begin
        m_exp_data = ref_mem[idx];
      end
    end
    if (r_pend && mem_resp_valid) r_pend = 0;
    if (mem_req_valid && mem_req_ready) begin
      chk("rnd_mem_req_owned", m_busy, 1);
      chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_mem_wen", mem_wen, m_wen);
      chk("rnd_mem_wmask", mem_wmask, m_wmask);
      if (m_wen) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      idx = mem_addr[3:2];
      if (mem_wen) begin
        sim_mem[idx] = apply_mask(sim_mem[idx], mem_wdata, mem_wmask);
        r_data = $urandom;
      end else begin
        r_data = sim_mem[idx];
      end
      r_pend = 1; s_wait = 0;
    end
    if (ifu_resp_valid || lsu_resp_valid) begin
      chk("rnd_resp_owner", {ifu_resp_valid, lsu_resp_valid},
          m_busy ? (m_owner_lsu ? 2'b01 : 2'b10) : 2'b00);
      chk("rnd_resp_data", m_owner_lsu ? lsu_rdata : ifu_rdata, m_exp_data);
      m_busy = 0; m_done++;
    end else if (m_busy) begin
      m_age++;
      if (m_age > 20) begin
        n_checks++; n_fail++;
        $display("FAIL rnd_resp_latency: got no response after %0d cycles, expected within 20", m_age);
        m_busy = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, expected $finish before 2ms");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{1, 1, 32'h8000_0000, 32'h8000_0200, 0, 32'h0, 4'hF, 32'h1111_2222,
                1, 32'h8000_0200, 0, 32'h0, 4'h0, 32'h1111_2222};
    vecs[1] = '{1, 1, 32'h8000_0004, 32'h8000_0204, 0, 32'h0, 4'h0, 32'h0000_0093,
                0, 32'h8000_0004, 0, 32'h0, 4'h0, 32'h0000_0093};
    vecs[2] = '{1, 1, 32'h8000_0008, 32'h8000_0208, 1, 32'hCAFE_F00D, 4'hC, 32'h5555_5555,
                1, 32'h8000_0208, 1, 32'hCAFE_F00D, 4'hC, 32'h0};
    vecs[3] = '{1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0413,
                0, 32'h8000_0000, 0, 32'h0, 4'h0, 32'h0000_0413};
    vecs[4] = '{1, 0, 32'h8000_0010, 32'h0, 0, 32'h0, 4'h0, 32'h1234_5678,
                0, 32'h8000_0010, 0, 32'h0, 4'h0, 32'h1234_5678};
    vecs[5] = '{1, 1, 32'h8000_0014, 32'h8000_0300, 0, 32'h0, 4'h0, 32'h8765_4321,
                1, 32'h8000_0300, 0, 32'h0, 4'h0, 32'h8765_4321};
    vecs[6] = '{0, 1, 32'h0, 32'h8000_0304, 1, 32'h0102_0304, 4'hF, 32'hAAAA_AAAA,
                1, 32'h8000_0304, 1, 32'h0102_0304, 4'hF, 32'h0};
    vecs[7] = '{1, 1, 32'h8000_0018, 32'h8000_0308, 0, 32'h0, 4'h0, 32'h0BAD_F00D,
                0, 32'h8000_0018, 0, 32'h0, 4'h0, 32'h0BAD_F00D};

    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_fields", {mem_addr, mem_wen, mem_wmask}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
    chk("rst_err", err, 0);

    // Tie-breaking, round-robin and single fetch, immediate memory
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Store with three cycles of backpressure
    tick();
    clear_inputs();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    @(negedge clk);
    chk("st_lsu_ready", lsu_req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_wen = 0;
      mem_req_ready = (i == 3);
      @(negedge clk);
      chk("st_mem_valid", mem_req_valid, 1);
      chk("st_mem_addr", mem_addr, 32'h8000_0100);
      chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_mem_wen_wmask", {mem_wen, mem_wmask}, 5'b1_0011);
    end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("st_resp_phase", {mem_req_valid, lsu_resp_valid}, 0);
    tick();
    mem_resp_valid = 0;
    @(negedge clk);
    chk("st_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 2'b01);
    chk("st_rdata", lsu_rdata, 0);

    // Watchdog timeout with a silent memory
    tick();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    chk("to_ifu_ready", ifu_req_ready, 1);
    for (int i = 0; i < TO; i++) begin
      tick();
      ifu_req_valid = 0;
      @(negedge clk);
      chk("to_waiting", {mem_req_valid, ifu_resp_valid, err}, 3'b100);
    end
    tick();
    @(negedge clk);
    chk("to_resp_valid", ifu_resp_valid, 1);
    chk("to_rdata", ifu_rdata, 0);
    chk("to_err", err, 1);
    chk("to_mem_valid", mem_req_valid, 0);
    tick();
    @(negedge clk);
    chk("to_single_pulse", ifu_resp_valid, 0);
    chk("to_err_sticky", err, 1);
    run_vec('{0, 1, 32'h0, 32'h8000_0400, 0, 32'h0, 4'h0, 32'h7777_0000,
              1, 32'h8000_0400, 0, 32'h0, 4'h0, 32'h7777_0000}, 8);
    chk("to_err_after_tx", err, 1);

    // Reset while waiting for the memory response
    tick();
    clear_inputs();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0500; mem_req_ready = 1;
    @(negedge clk);
    chk("rm_lsu_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0;
    @(negedge clk);
    chk("rm_req_state", mem_req_valid, 1);
    tick();
    rst = 1; mem_req_ready = 0;
    @(negedge clk);
    chk("rm_resp_state", mem_req_valid, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rm_after_rst", {mem_req_valid, err, ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rm_outputs_cleared", {mem_addr, lsu_rdata}, 0);
    tick();
    mem_resp_valid = 1; mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("rm_stray_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    tick();
    mem_resp_valid = 0;
    @(negedge clk);
    chk("rm_stray_ignored", {mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 0);

    // IFU request pulsed and withdrawn while an LSU load is outstanding
    tick();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0600; mem_req_ready = 1;
    @(negedge clk);
    chk("wd_lsu_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 0;
    @(negedge clk);
    tick();
    mem_req_ready = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0700;
    @(negedge clk);
    chk("wd_ifu_ready_resp", ifu_req_ready, 0);
    tick();
    ifu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("wd_ifu_ready_resp2", ifu_req_ready, 0);
    tick();
    mem_resp_valid = 0;
    @(negedge clk);
    chk("wd_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 2'b01);
    chk("wd_rdata", lsu_rdata, 32'h1357_9BDF);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("wd_no_extra_req", {mem_req_valid, ifu_resp_valid}, 0);
    end

    // Randomized traffic against the reference model
    reset_dut();
    m_busy = 0; m_owner_lsu = 0; m_last_lsu = 0; m_age = 0; m_done = 0;
    m_addr = 0; m_wen = 0; m_wdata = 0; m_wmask = 0; m_exp_data = 0;
    r_pend = 0; r_data = 0; q_wait = 0; s_wait = 0;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = 32'hA0A0_0000 + 32'(i);
      sim_mem[i] = 32'hA0A0_0000 + 32'(i);
    end
    for (int c = 0; c < 2000; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 30; c++) rnd_cycle(1'b0);
    chk("rnd_drained", m_busy, 0);
    chk("rnd_progress", m_done > 200, 1);
    chk("rnd_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
